uart_rx_deframe: RTL and testbench

- Receive-side counterpart of the transmitter frame generator.
- Recovers one 11-bit-max UART frame from the serial line: start bit (0), 8 data bits LSB first, optional parity bit, one stop bit (1).
- Oversamples the line on a shared baud tick, checks parity and stop bit, and presents the byte with a one-cycle valid pulse and error flags.
- Sits between the pad/line input and the RX buffer.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_rx_deframe_if.sv | 16 +
 rtl/uart_rx_sync.sv | 36 +++
 rtl/uart_rx_deframe.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_deframe.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
// Contents: parity_t (parity_type encoding), rx_state_t (receive FSM
// states) and the start/stop bit levels and maximum frame width.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE0 = 2'b00,
    PAR_ODD   = 2'b01,
    PAR_EVEN  = 2'b10,
    PAR_NONE3 = 2'b11
  } parity_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic        START_BIT   = 1'b0;
  localparam logic        STOP_BIT    = 1'b1;
  localparam int unsigned FRAME_MAX_W = 11;

endpackage

// File: rtl/uart_rx_deframe_if.sv
// Received-byte bus from the UART deframer to the RX buffer.
// Signals: data_out (byte, held until next valid), data_valid (one-clk
// pulse), parity_err / stop_err (qualified by data_valid), busy.
// Modports: master = deframer side (drives), slave = consumer side.
interface uart_rx_deframe_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              parity_err;
  logic              stop_err;
  logic              busy;

  modport master (output data_out, data_valid, parity_err, stop_err, busy);
  modport slave  (input  data_out, data_valid, parity_err, stop_err, busy);
endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a
// falling-edge detector on the synchronized value.
// Ports: clk, rst_n (async active-low), rx_in (raw line),
//        line (synchronized line, reset 1), fall_c (falling edge, comb).
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx_in,
  output logic line,
  output logic fall_c
);

  logic       sync1;
  logic       line_d;
  logic [1:0] warm;

  // Synchronizer chain; warm counts clocks since reset so the reset-value
  // ones are not mistaken for a line that was actually observed high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      line   <= 1'b1;
      line_d <= 1'b1;
      warm   <= 2'd0;
    end else begin
      sync1  <= rx_in;
      line   <= sync1;
      line_d <= line;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  // Edge only counts once line_d carries a genuinely sampled value.
  assign fall_c = (warm == 2'd3) && line_d && !line;

endmodule

// File: rtl/uart_rx_deframe.sv
// UART receive deframer: start bit, DATA_W data bits LSB first, optional
// parity bit, one stop bit. Oversamples the synchronized line on tick_en,
// checks parity and stop bit, presents the byte with a one-clk valid pulse.
// Ports: clk, rst_n (async active-low), tick_en (oversample tick),
//        rx_in (serial line), parity_type (00/11 none, 01 odd, 10 even),
//        rx_if (master: data_out, data_valid, parity_err, stop_err, busy).
// Build option: UART_RX_MAJORITY_VOTE_EN -- each bit is the 2-of-3 majority
// of the samples at mid-1, mid, mid+1, decided at mid+1.
module uart_rx_deframe
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick_en,
  input  logic                    rx_in,
  input  logic [1:0]              parity_type,
  uart_rx_deframe_if.master       rx_if
);

  localparam int unsigned CW = $clog2(OVERSAMPLE);
  localparam int unsigned IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned BIT_PT = OVERSAMPLE - 1;
`ifdef UART_RX_MAJORITY_VOTE_EN
  // Decision one tick late; the delay carries into every following bit.
  localparam int unsigned START_PT = OVERSAMPLE / 2;
`else
  localparam int unsigned START_PT = OVERSAMPLE / 2 - 1;
`endif

  logic line;
  logic fall_c;
  logic bit_c;

  uart_rx_sync u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx_in  (rx_in),
    .line   (line),
    .fall_c (fall_c)
  );

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;

  // Line values at the two previous ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       hist_q <= 2'b11;
    else if (tick_en) hist_q <= {hist_q[0], line};
  end

  assign bit_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & line) | (hist_q[0] & line);
`else
  assign bit_c = line;
`endif

  rx_state_t         state_q, state_n;
  logic [CW-1:0]     cnt_q, cnt_n;
  logic [IW-1:0]     idx_q, idx_n;
  logic [DATA_W-1:0] shreg_q, shreg_n;
  parity_t           par_q, par_n;
  logic              perr_q, perr_n;
  logic [DATA_W-1:0] dout_n;
  logic              valid_n, perr_out_n, serr_n, busy_n;
  logic              start_hit, bit_hit;

  assign start_hit = tick_en && (cnt_q == CW'(START_PT));
  assign bit_hit   = tick_en && (cnt_q == CW'(BIT_PT));

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      idx_q            <= '0;
      shreg_q          <= '0;
      par_q            <= PAR_NONE0;
      perr_q           <= 1'b0;
      rx_if.data_out   <= '0;
      rx_if.data_valid <= 1'b0;
      rx_if.parity_err <= 1'b0;
      rx_if.stop_err   <= 1'b0;
      rx_if.busy       <= 1'b0;
    end else begin
      state_q          <= state_n;
      cnt_q            <= cnt_n;
      idx_q            <= idx_n;
      shreg_q          <= shreg_n;
      par_q            <= par_n;
      perr_q           <= perr_n;
      rx_if.data_out   <= dout_n;
      rx_if.data_valid <= valid_n;
      rx_if.parity_err <= perr_out_n;
      rx_if.stop_err   <= serr_n;
      rx_if.busy       <= busy_n;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state_q;
    idx_n      = idx_q;
    shreg_n    = shreg_q;
    par_n      = par_q;
    perr_n     = perr_q;
    dout_n     = rx_if.data_out;
    valid_n    = 1'b0;
    perr_out_n = rx_if.parity_err;
    serr_n     = rx_if.stop_err;

    unique case (state_q)
      IDLE: begin
        if (fall_c) begin
          state_n = START;
          par_n   = parity_t'(parity_type);
          perr_n  = 1'b0;
        end
      end
      START: begin
        if (start_hit) begin
          state_n = (bit_c == START_BIT) ? DATA : IDLE;
          idx_n   = '0;
        end
      end
      DATA: begin
        if (bit_hit) begin
          shreg_n = {bit_c, shreg_q[DATA_W-1:1]};
          idx_n   = idx_q + IW'(1);
          if (idx_q == IW'(DATA_W - 1))
            state_n = (par_q == PAR_ODD || par_q == PAR_EVEN) ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_hit) begin
          // Odd errs when the total XOR is 0, even when it is 1.
          perr_n  = (^shreg_q) ^ bit_c ^ (par_q == PAR_ODD);
          state_n = STOP;
        end
      end
      STOP: begin
        if (bit_hit) begin
          dout_n     = shreg_q;
          valid_n    = 1'b1;
          perr_out_n = perr_q;
          serr_n     = (bit_c != STOP_BIT);
          state_n    = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Tick counter restarts on every state entry, wraps once per bit.
    cnt_n = cnt_q;
    if (state_n != state_q)
      cnt_n = '0;
    else if (tick_en)
      cnt_n = (cnt_q == CW'(BIT_PT)) ? '0 : cnt_q + CW'(1);

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_uart_rx_deframe.sv
// Self-checking bench for uart_rx_deframe (OVERSAMPLE=16, DATA_W=8,
// tick_en held high so one bit period is 16 clocks).
module tb_uart_rx_deframe;
  import uart_pkg::*;

`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VOTE_EXTRA = 1;
  localparam logic [7:0] SPIKE_EXP = 8'h00;
`else
  localparam int VOTE_EXTRA = 0;
  localparam logic [7:0] SPIKE_EXP = 8'h04;
`endif
  localparam int LAT_NP = 155 + VOTE_EXTRA;  // start edge drive -> valid, no parity
  localparam int LAT_P  = 171 + VOTE_EXTRA;  // with parity bit

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tick_en;
  logic       rx_in;
  logic [1:0] parity_type;

  uart_rx_deframe_if #(.DATA_W(8)) rx_if ();

  uart_rx_deframe #(.OVERSAMPLE(16), .DATA_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_en     (tick_en),
    .rx_in       (rx_in),
    .parity_type (parity_type),
    .rx_if       (rx_if)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Valid-pulse monitor: captures each result and checks the pulse width.
  int         nvalid = 0;
  logic [7:0] cap_data [64];
  logic       cap_perr [64];
  logic       cap_serr [64];
  int         cap_cyc  [64];
  logic       prev_valid = 1'b0;
  logic       busy_seen  = 1'b0;
  always @(negedge clk) begin
    if (rx_if.busy === 1'b1) busy_seen = 1'b1;
    if (rx_if.data_valid === 1'b1) begin
      check("valid_width", 32'(prev_valid), 32'd0);
      cap_data[nvalid % 64] = rx_if.data_out;
      cap_perr[nvalid % 64] = rx_if.parity_err;
      cap_serr[nvalid % 64] = rx_if.stop_err;
      cap_cyc[nvalid % 64]  = cyc;
      nvalid++;
    end
    prev_valid = rx_if.data_valid;
  end

  // Hold the line at v for n clocks; always returns 1 time unit after a posedge.
  task automatic hold(input logic v, input int n);
    rx_in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Send one frame; parity_type is flipped after the start bit to show it is latched.
  task automatic send_frame(input logic [7:0] d, input logic [1:0] pt, input logic pb,
                            input logic sb, output int c0);
    parity_type = pt;
    c0 = cyc;
    hold(1'b0, 16);
    parity_type = ~pt;
    for (int i = 0; i < 8; i++) hold(d[i], 16);
    if (pt == 2'b01 || pt == 2'b10) hold(pb, 16);
    hold(sb, 16);
    parity_type = pt;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [1:0] ptype;
    logic       pbit;
    logic [7:0] exp_data;
    logic       exp_perr;
    int         exp_lat;
  } vec_t;

  vec_t vecs [8];

  // Whole-run watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int c0, c1, n0;
    vecs[0] = '{8'hA5, 2'b00, 1'b0, 8'hA5, 1'b0, LAT_NP};
    vecs[1] = '{8'h03, 2'b01, 1'b1, 8'h03, 1'b0, LAT_P};
    vecs[2] = '{8'h03, 2'b01, 1'b0, 8'h03, 1'b1, LAT_P};
    vecs[3] = '{8'h00, 2'b10, 1'b0, 8'h00, 1'b0, LAT_P};
    vecs[4] = '{8'h00, 2'b10, 1'b1, 8'h00, 1'b1, LAT_P};
    vecs[5] = '{8'hFF, 2'b01, 1'b1, 8'hFF, 1'b0, LAT_P};
    vecs[6] = '{8'h81, 2'b11, 1'b0, 8'h81, 1'b0, LAT_NP};
    vecs[7] = '{8'h3C, 2'b00, 1'b1, 8'h3C, 1'b0, LAT_NP};

    rst_n = 1'b0; tick_en = 1'b1; rx_in = 1'b1; parity_type = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  32'(rx_if.data_out),   32'h0);
    check("rst_valid", 32'(rx_if.data_valid), 32'h0);
    check("rst_perr",  32'(rx_if.parity_err), 32'h0);
    check("rst_serr",  32'(rx_if.stop_err),   32'h0);
    check("rst_busy",  32'(rx_if.busy),       32'h0);
    rst_n = 1'b1;
    hold(1'b1, 10);

    // Table of single frames with a good stop bit.
    foreach (vecs[k]) begin
      n0 = nvalid;
      send_frame(vecs[k].data, vecs[k].ptype, vecs[k].pbit, 1'b1, c0);
      hold(1'b1, 20);
      check($sformatf("v%0d_count", k), 32'(nvalid - n0), 32'd1);
      check($sformatf("v%0d_data", k),  32'(cap_data[n0 % 64]), 32'(vecs[k].exp_data));
      check($sformatf("v%0d_perr", k),  32'(cap_perr[n0 % 64]), 32'(vecs[k].exp_perr));
      check($sformatf("v%0d_serr", k),  32'(cap_serr[n0 % 64]), 32'd0);
      check($sformatf("v%0d_lat", k),   32'(cap_cyc[n0 % 64] - c0), 32'(vecs[k].exp_lat));
      check($sformatf("v%0d_busy", k),  32'(rx_if.busy), 32'd0);
    end

    // Stop bit low, then line held low: no new start until it goes high.
    n0 = nvalid;
    send_frame(8'h07, 2'b10, 1'b1, 1'b0, c0);
    hold(1'b0, 80);
    check("se_count", 32'(nvalid - n0), 32'd1);
    check("se_data",  32'(cap_data[n0 % 64]), 32'h07);
    check("se_perr",  32'(cap_perr[n0 % 64]), 32'd0);
    check("se_serr",  32'(cap_serr[n0 % 64]), 32'd1);
    check("se_busy_low", 32'(rx_if.busy), 32'd0);
    hold(1'b1, 20);
    check("se_busy_high", 32'(rx_if.busy), 32'd0);
    n0 = nvalid;
    send_frame(8'h5A, 2'b00, 1'b0, 1'b1, c0);
    hold(1'b1, 20);
    check("se_recover_count", 32'(nvalid - n0), 32'd1);
    check("se_recover_data",  32'(cap_data[n0 % 64]), 32'h5A);
    check("se_recover_serr",  32'(cap_serr[n0 % 64]), 32'd0);

    // 4-clock low glitch: false start.
    n0 = nvalid;
    busy_seen = 1'b0;
    hold(1'b0, 4);
    hold(1'b1, 30);
    check("gl_busy_seen", 32'(busy_seen), 32'd1);
    check("gl_count", 32'(nvalid - n0), 32'd0);
    check("gl_busy", 32'(rx_if.busy), 32'd0);

    // Back-to-back frames, no idle gap.
    n0 = nvalid;
    send_frame(8'h55, 2'b00, 1'b0, 1'b1, c0);
    send_frame(8'hAA, 2'b00, 1'b0, 1'b1, c1);
    hold(1'b1, 20);
    check("b2b_count", 32'(nvalid - n0), 32'd2);
    check("b2b_data0", 32'(cap_data[n0 % 64]), 32'h55);
    check("b2b_data1", 32'(cap_data[(n0 + 1) % 64]), 32'hAA);
    check("b2b_lat1",  32'(cap_cyc[(n0 + 1) % 64] - c1), 32'(LAT_NP));

    // Spike at the middle of data bit 2 of 0x00.
    n0 = nvalid;
    c0 = cyc;
    hold(1'b0, 16);
    hold(1'b0, 16);
    hold(1'b0, 16);
    hold(1'b0, 8);
    hold(1'b1, 1);
    hold(1'b0, 7);
    for (int i = 3; i < 8; i++) hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b1, 20);
    check("sp_count", 32'(nvalid - n0), 32'd1);
    check("sp_data",  32'(cap_data[n0 % 64]), 32'(SPIKE_EXP));

    // Back-to-back again with reset during bit 3 of the second frame.
    n0 = nvalid;
    send_frame(8'h55, 2'b00, 1'b0, 1'b1, c0);
    hold(1'b0, 16);
    hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b0, 16);
    hold(1'b1, 5);
    #3;
    rst_n = 1'b0;
    #1;
    check("mr_pre_count", 32'(nvalid - n0), 32'd1);
    check("mr_data",  32'(rx_if.data_out),   32'h0);
    check("mr_valid", 32'(rx_if.data_valid), 32'h0);
    check("mr_busy",  32'(rx_if.busy),       32'h0);
    check("mr_serr",  32'(rx_if.stop_err),   32'h0);
    hold(1'b1, 11);
    hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b0, 16);
    hold(1'b1, 16);
    hold(1'b1, 16);
    rst_n = 1'b1;
    hold(1'b1, 200);
    check("mr_post_count", 32'(nvalid - n0), 32'd1);
    check("mr_post_busy",  32'(rx_if.busy), 32'd0);
    check("mr_post_data",  32'(rx_if.data_out), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
